// File: rtl/t5_lsu.sv
// Memory-stage load/store unit: misalignment check, single Wishbone-style data cycle with
// watchdog, and sign/zero-extended load return to writeback.
module t5_lsu #(
  parameter int unsigned TOUT = 255
) (
  input  logic        sclk,
  input  logic        srst,
  input  logic        sena,
  input  logic [4:0]  xopc,
  input  logic [2:0]  xfn3,
  input  logic [31:0] xea,
  input  logic [31:0] xdat,
  output logic [1:0]  xstb,
  output logic        xwre,
  output logic        lstall,
  output logic [31:0] mdat,
  output logic        mvld,
  output logic        merr,
  output logic        dwb_cyc,
  output logic        dwb_stb,
  output logic        dwb_we,
  output logic [29:0] dwb_adr,
  output logic [3:0]  dwb_sel,
  output logic [31:0] dwb_dto,
  input  logic [31:0] dwb_dti,
  input  logic        dwb_ack,
  input  logic        dwb_err
);

  localparam logic [4:0] OpLoad  = 5'b00000;
  localparam logic [4:0] OpStore = 5'b01000;

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  state_e      state_q, state_d;
  logic [1:0]  xstb_q, xstb_d;
  logic        xwre_q, xwre_d;
  logic [31:0] mdat_q, mdat_d;
  logic        mvld_q, mvld_d;
  logic        merr_q, merr_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dto_q, dto_d;
  logic [2:0]  fn3_q, fn3_d;
  logic [1:0]  a_q, a_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        is_store, mem_op, misal, bus, timeout;
  logic [3:0]  sel_new;
  logic [31:0] dti_sh, ld_ext;

  assign is_store = (xopc == OpStore);
  assign mem_op   = (xopc == OpLoad) || is_store;
  assign bus      = (state_q == StBus);
  assign timeout  = bus && (cnt_q == 8'(TOUT - 1));

  always_comb begin
    misal   = 1'b0;
    sel_new = 4'b1111;
    unique case (xfn3[1:0])
      2'b00: sel_new = 4'b0001 << xea[1:0];
      2'b01: begin
        misal   = xea[0];
        sel_new = xea[1] ? 4'b1100 : 4'b0011;
      end
      default: misal = |xea[1:0];
    endcase
  end

  // Byte lane a is shifted down to bits [7:0]; halves only ever sit at lane 0 or 2.
  assign dti_sh = dwb_dti >> {a_q, 3'b000};

  always_comb begin
    ld_ext = dwb_dti;
    unique case (fn3_q[1:0])
      2'b00:   ld_ext = {{24{~fn3_q[2] & dti_sh[7]}}, dti_sh[7:0]};
      2'b01:   ld_ext = {{16{~fn3_q[2] & dti_sh[15]}}, dti_sh[15:0]};
      default: ld_ext = dwb_dti;
    endcase
  end

  always_comb begin
    state_d = state_q;
    xstb_d  = xstb_q;
    xwre_d  = xwre_q;
    mdat_d  = mdat_q;
    mvld_d  = 1'b0;
    merr_d  = 1'b0;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dto_d   = dto_q;
    fn3_d   = fn3_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (sena && mem_op) begin
          xstb_d = {1'b1, misal};
          xwre_d = is_store;
          if (!misal) begin
            adr_d   = xea[31:2];
            dto_d   = xdat;
            we_d    = is_store;
            sel_d   = sel_new;
            fn3_d   = xfn3;
            a_d     = xea[1:0];
            state_d = StBus;
          end
        end else if (sena) begin
          xstb_d = 2'b00;
        end
      end
      StBus: begin
        cnt_d = cnt_q + 8'd1;
        if (dwb_ack) begin
          if (!we_q) begin
            mdat_d = ld_ext;
            mvld_d = 1'b1;
          end
          state_d = StIdle;
        end else if (dwb_err || timeout) begin
          merr_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state_q <= StIdle;
      xstb_q  <= 2'b00;
      xwre_q  <= 1'b0;
      mdat_q  <= 32'd0;
      mvld_q  <= 1'b0;
      merr_q  <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 30'd0;
      sel_q   <= 4'd0;
      dto_q   <= 32'd0;
      fn3_q   <= 3'd0;
      a_q     <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      xstb_q  <= xstb_d;
      xwre_q  <= xwre_d;
      mdat_q  <= mdat_d;
      mvld_q  <= mvld_d;
      merr_q  <= merr_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dto_q   <= dto_d;
      fn3_q   <= fn3_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lstall  = bus && !dwb_ack && !dwb_err && !timeout;
  assign xstb    = xstb_q;
  assign xwre    = xwre_q;
  assign mdat    = mdat_q;
  assign mvld    = mvld_q;
  assign merr    = merr_q;
  assign dwb_cyc = bus;
  assign dwb_stb = bus;
  assign dwb_we  = we_q;
  assign dwb_adr = adr_q;
  assign dwb_sel = sel_q;
  assign dwb_dto = dto_q;

endmodule

// File: tb/tb_t5_lsu.sv
// Directed bench for t5_lsu: vector table of single memory ops plus hand sequences for
// watchdog timeout, bus error and mid-transaction reset.
module tb_t5_lsu;

  logic        sclk = 1'b0;
  logic        srst = 1'b0;
  logic        sena = 1'b0;
  logic [4:0]  xopc = 5'b00100;
  logic [2:0]  xfn3 = 3'd0;
  logic [31:0] xea = 32'd0;
  logic [31:0] xdat = 32'd0;
  logic [1:0]  xstb;
  logic        xwre, lstall, mvld, merr;
  logic [31:0] mdat;
  logic        dwb_cyc, dwb_stb, dwb_we;
  logic [29:0] dwb_adr;
  logic [3:0]  dwb_sel;
  logic [31:0] dwb_dto;
  logic [31:0] dwb_dti = 32'd0;
  logic        dwb_ack = 1'b0;
  logic        dwb_err = 1'b0;

  int npass = 0;
  int ntot  = 0;

  always #5 sclk = ~sclk;

  t5_lsu #(.TOUT(4)) dut (
    .sclk    (sclk),
    .srst    (srst),
    .sena    (sena),
    .xopc    (xopc),
    .xfn3    (xfn3),
    .xea     (xea),
    .xdat    (xdat),
    .xstb    (xstb),
    .xwre    (xwre),
    .lstall  (lstall),
    .mdat    (mdat),
    .mvld    (mvld),
    .merr    (merr),
    .dwb_cyc (dwb_cyc),
    .dwb_stb (dwb_stb),
    .dwb_we  (dwb_we),
    .dwb_adr (dwb_adr),
    .dwb_sel (dwb_sel),
    .dwb_dto (dwb_dto),
    .dwb_dti (dwb_dti),
    .dwb_ack (dwb_ack),
    .dwb_err (dwb_err)
  );

  // kind: 0 = aligned bus op, 1 = misaligned, 2 = non-memory op
  typedef struct {
    logic [4:0]  opc;
    logic [2:0]  fn3;
    logic [31:0] ea;
    logic [31:0] dat;
    logic [31:0] dti;
    int          wt;
    int          kind;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] mdat;
    logic        mvld;
    logic [1:0]  xstb;
    logic        xwre;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic accept(input logic [4:0] opc, input logic [2:0] fn3, input logic [31:0] ea,
                        input logic [31:0] dat);
    @(negedge sclk);
    sena = 1'b1;
    xopc = opc;
    xfn3 = fn3;
    xea  = ea;
    xdat = dat;
    @(posedge sclk);
    #1;
    sena = 1'b0;
    xopc = 5'b00100;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    accept(v.opc, v.fn3, v.ea, v.dat);
    @(negedge sclk);
    chk($sformatf("v%0d.xstb", idx), xstb, v.xstb);
    chk($sformatf("v%0d.xwre", idx), xwre, v.xwre);
    if (v.kind != 0) begin
      chk($sformatf("v%0d.nostb", idx), dwb_stb, 0);
      chk($sformatf("v%0d.mdat", idx), mdat, v.mdat);
      return;
    end
    chk($sformatf("v%0d.stb", idx), dwb_stb, 1);
    chk($sformatf("v%0d.sel", idx), dwb_sel, v.sel);
    chk($sformatf("v%0d.we", idx), dwb_we, v.we);
    chk($sformatf("v%0d.adr", idx), dwb_adr, v.ea[31:2]);
    chk($sformatf("v%0d.dto", idx), dwb_dto, v.dat);
    stalls = 0;
    for (int i = 0; i < v.wt; i++) begin
      #1;
      stalls += int'(lstall);
      @(negedge sclk);
    end
    dwb_ack = 1'b1;
    dwb_dti = v.dti;
    #1;
    chk($sformatf("v%0d.stall_resp", idx), lstall, 0);
    chk($sformatf("v%0d.stalls", idx), stalls, v.wt);
    @(posedge sclk);
    #1;
    dwb_ack = 1'b0;
    @(negedge sclk);
    chk($sformatf("v%0d.mvld", idx), mvld, v.mvld);
    chk($sformatf("v%0d.mdat", idx), mdat, v.mdat);
    chk($sformatf("v%0d.merr", idx), merr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int stalls;
    logic seen_merr;
    vecs[0]  = '{5'b00000, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 4'hF, 1'b0,
                 32'hDEADBEEF, 1'b1, 2'b10, 1'b0};
    vecs[1]  = '{5'b00000, 3'd0, 32'h203, 32'h0, 32'h80FF0000, 0, 0, 4'b1000, 1'b0,
                 32'hFFFFFF80, 1'b1, 2'b10, 1'b0};
    vecs[2]  = '{5'b00000, 3'd4, 32'h203, 32'h0, 32'h80FF0000, 1, 0, 4'b1000, 1'b0,
                 32'h00000080, 1'b1, 2'b10, 1'b0};
    vecs[3]  = '{5'b01000, 3'd1, 32'h302, 32'h12341234, 32'hFFFFFFFF, 0, 0, 4'b1100, 1'b1,
                 32'h00000080, 1'b0, 2'b10, 1'b1};
    vecs[4]  = '{5'b01000, 3'd2, 32'h401, 32'h0, 32'h0, 0, 1, 4'h0, 1'b0,
                 32'h00000080, 1'b0, 2'b11, 1'b1};
    vecs[5]  = '{5'b00000, 3'd1, 32'h402, 32'h0, 32'h80017FFF, 1, 0, 4'b1100, 1'b0,
                 32'hFFFF8001, 1'b1, 2'b10, 1'b0};
    vecs[6]  = '{5'b00000, 3'd5, 32'h400, 32'h0, 32'h80018765, 0, 0, 4'b0011, 1'b0,
                 32'h00008765, 1'b1, 2'b10, 1'b0};
    vecs[7]  = '{5'b00000, 3'd0, 32'h001, 32'h0, 32'h00007F00, 0, 0, 4'b0010, 1'b0,
                 32'h0000007F, 1'b1, 2'b10, 1'b0};
    vecs[8]  = '{5'b01000, 3'd0, 32'h003, 32'hABABABAB, 32'h0, 1, 0, 4'b1000, 1'b1,
                 32'h0000007F, 1'b0, 2'b10, 1'b1};
    vecs[9]  = '{5'b01100, 3'd0, 32'h004, 32'h0, 32'h0, 0, 2, 4'h0, 1'b0,
                 32'h0000007F, 1'b0, 2'b00, 1'b1};
    vecs[10] = '{5'b00000, 3'd1, 32'h403, 32'h0, 32'h0, 0, 1, 4'h0, 1'b0,
                 32'h0000007F, 1'b0, 2'b11, 1'b0};

    // Reset state
    #12;
    chk("rst.stb", dwb_stb, 0);
    chk("rst.xstb", xstb, 0);
    chk("rst.mdat", mdat, 0);
    srst = 1'b1;

    // Op presented with sena low is ignored
    @(negedge sclk);
    xopc = 5'b00000;
    xfn3 = 3'd2;
    xea  = 32'h100;
    @(posedge sclk);
    @(negedge sclk);
    chk("noena.stb", dwb_stb, 0);
    chk("noena.xstb", xstb, 0);
    xopc = 5'b00100;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Watchdog: never acknowledged, TOUT=4
    accept(5'b00000, 3'd2, 32'h500, 32'h0);
    n = 0;
    stalls = 0;
    seen_merr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sclk);
      if (merr) begin
        seen_merr = 1'b1;
        break;
      end
      n += int'(dwb_stb);
      stalls += int'(lstall);
    end
    chk("tout.merr", seen_merr, 1);
    chk("tout.buscycles", n, 4);
    chk("tout.stalls", stalls, 3);
    chk("tout.mvld", mvld, 0);
    chk("tout.mdat", mdat, 32'h7F);
    chk("tout.lstall", lstall, 0);

    // Bus error in second BUS cycle
    accept(5'b00000, 3'd2, 32'h504, 32'h0);
    @(negedge sclk);
    #1;
    chk("err.stall1", lstall, 1);
    @(negedge sclk);
    dwb_err = 1'b1;
    dwb_dti = 32'h11111111;
    #1;
    chk("err.stall2", lstall, 0);
    @(posedge sclk);
    #1;
    dwb_err = 1'b0;
    @(negedge sclk);
    chk("err.merr", merr, 1);
    chk("err.mvld", mvld, 0);
    chk("err.mdat", mdat, 32'h7F);

    // Async reset mid-BUS
    accept(5'b01000, 3'd2, 32'h600, 32'h55);
    @(negedge sclk);
    chk("mrst.stb_before", dwb_stb, 1);
    chk("mrst.we_before", dwb_we, 1);
    srst = 1'b0;
    #1;
    chk("mrst.cyc", dwb_cyc, 0);
    chk("mrst.stb", dwb_stb, 0);
    chk("mrst.we", dwb_we, 0);
    chk("mrst.xstb", xstb, 0);
    chk("mrst.xwre", xwre, 0);
    chk("mrst.sel", dwb_sel, 0);
    chk("mrst.adr", dwb_adr, 0);
    chk("mrst.dto", dwb_dto, 0);
    chk("mrst.mdat", mdat, 0);
    chk("mrst.lstall", lstall, 0);
    @(negedge sclk);
    srst = 1'b1;
    run_vec(vecs[0], 100);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
